// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared opcodes, FSM state type and width defaults for alu_arbiter
package alu_arb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int OP_W_DEF   = 3;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_AND = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // 011 and 111 have no ALU meaning; only the optional error path looks at this
    function automatic logic is_illegal_op(input logic [2:0] op);
        return (op == 3'b011) || (op == 3'b111);
    endfunction

endpackage

// File: rtl/alu_arb_rr_pick.sv
// rtl/alu_arb_rr_pick.sv - combinational 2-way round-robin grant
module alu_arb_rr_pick (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant0,
    output logic grant1
);

    // On a tie the requester that did not win last time is served
    always_comb begin
        grant0 = valid0 & (~valid1 | last_grant);
        grant1 = valid1 & (~valid0 | ~last_grant);
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU between two requesters (option: ALU_ARB_ILLEGAL_OP_EN)
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  op_count
);

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              lat_id_q, lat_id_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;

    logic              grant0, grant1;
    logic              accept;
    logic [OP_W-1:0]   sel_op;
    logic [DATA_W-1:0] sel_a, sel_b;

    alu_arb_rr_pick u_rr_pick (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant_q),
        .grant0     (grant0),
        .grant1     (grant1)
    );

    always_comb begin
        req0_ready = (state_q == IDLE) & grant0;
        req1_ready = (state_q == IDLE) & grant1;
        accept     = req0_ready | req1_ready;
        sel_op     = grant1 ? req1_op : req0_op;
        sel_a      = grant1 ? req1_a  : req0_a;
        sel_b      = grant1 ? req1_b  : req0_b;
    end

`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic lat_err_q, lat_err_d;
    logic rsp_err_q, rsp_err_d;
    logic sel_illegal;

    always_comb begin
        sel_illegal = is_illegal_op(3'(sel_op));
    end
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        lat_id_d     = lat_id_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        op_count_d   = op_count_q;
`ifdef ALU_ARB_ILLEGAL_OP_EN
        lat_err_d    = lat_err_q;
        rsp_err_d    = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = EXEC;
                    last_grant_d = grant1;
                    lat_id_d     = grant1;
`ifdef ALU_ARB_ILLEGAL_OP_EN
                    lat_err_d    = sel_illegal;
                    // An illegal op never reaches the ALU, so its inputs keep their old values
                    if (!sel_illegal) begin
                        alu_a_d  = sel_a;
                        alu_b_d  = sel_b;
                        alu_op_d = sel_op;
                    end
`else
                    alu_a_d      = sel_a;
                    alu_b_d      = sel_b;
                    alu_op_d     = sel_op;
`endif
                end
            end
            EXEC: begin
                state_d  = RESP;
                rsp_id_d = lat_id_q;
`ifdef ALU_ARB_ILLEGAL_OP_EN
                rsp_err_d    = lat_err_q;
                rsp_result_d = lat_err_q ? '0   : alu_result;
                rsp_zero_d   = lat_err_q ? 1'b1 : alu_zero;
`else
                rsp_result_d = alu_result;
                rsp_zero_d   = alu_zero;
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d    = IDLE;
                    op_count_d = op_count_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            lat_id_q     <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lat_id_q     <= lat_id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            op_count_q   <= op_count_d;
        end
    end

`ifdef ALU_ARB_ILLEGAL_OP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_err_q <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            lat_err_q <= lat_err_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized and directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_op = '0, req1_op = '0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_op;
    logic        alu_zero;
    logic        rsp_valid, rsp_id, rsp_zero, rsp_err;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic [15:0] op_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .op_count(op_count)
    );

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000:  return a + b;
            3'b100:  return a - b;
            3'b001:  return a & b;
            3'b101:  return a | b;
            3'b010:  return a ^ b;
            3'b110:  return b << 16;
            default: return a + b;
        endcase
    endfunction

    assign alu_result = alu_ref(alu_op, alu_a, alu_b);
    assign alu_zero   = (alu_result == 32'd0);

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Transaction-level reference: one op in flight at a time, response two cycles after accept
    logic        m_pend = 1'b0;
    int          m_age  = 0;
    logic        m_last = 1'b1;
    int unsigned m_cnt  = 0;
    logic        e_id, e_zero, e_err;
    logic [31:0] e_res;
    logic [31:0] hold_a = '0, hold_b = '0;
    logic [2:0]  hold_op = '0;
    int          acc_ids[$];

    function automatic logic illegal(input logic [2:0] op);
`ifdef ALU_ARB_ILLEGAL_OP_EN
        return (op == 3'b011) || (op == 3'b111);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_pend = 1'b0; m_age = 0; m_last = 1'b1; m_cnt = 0;
        hold_a = '0; hold_b = '0; hold_op = '0;
    endtask

    // Inputs are already driven; check this cycle, advance the model across the edge, return at next negedge
    task automatic step();
        logic er0, er1, ev;
        logic [2:0]  op;
        logic [31:0] a, b;
        #1;
        er0 = !m_pend && req0_valid && (!req1_valid || m_last);
        er1 = !m_pend && req1_valid && (!req0_valid || !m_last);
        ev  = m_pend && (m_age >= 2);
        check_eq("req0_ready", req0_ready, er0);
        check_eq("req1_ready", req1_ready, er1);
        check_eq("rsp_valid", rsp_valid, ev);
        check_eq("op_count", op_count, m_cnt[15:0]);
        if (ev) begin
            check_eq("rsp_id", rsp_id, e_id);
            check_eq("rsp_result", rsp_result, e_res);
            check_eq("rsp_zero", rsp_zero, e_zero);
            check_eq("rsp_err", rsp_err, e_err);
        end
        if (m_pend && m_age == 1) begin
            check_eq("alu_a", alu_a, hold_a);
            check_eq("alu_b", alu_b, hold_b);
            check_eq("alu_op", alu_op, hold_op);
        end
        if (m_pend) begin
            if (ev && rsp_ready) begin
                m_pend = 1'b0;
                m_cnt  = (m_cnt + 1) % 65536;
            end else begin
                m_age++;
            end
        end else if (er0 || er1) begin
            op = er1 ? req1_op : req0_op;
            a  = er1 ? req1_a  : req0_a;
            b  = er1 ? req1_b  : req0_b;
            m_pend = 1'b1; m_age = 1; m_last = er1;
            acc_ids.push_back(er1 ? 1 : 0);
            e_id = er1;
            if (illegal(op)) begin
                e_res = '0; e_zero = 1'b1; e_err = 1'b1;
            end else begin
                e_res = alu_ref(op, a, b); e_zero = (e_res == 0); e_err = 1'b0;
                hold_a = a; hold_b = b; hold_op = op;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input int id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (id == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    task automatic run_one(input int id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] x_res, input logic x_zero, input logic x_err);
        drive(id, op, a, b);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        #1;
        check_eq("lit_rsp_valid", rsp_valid, 1'b1);
        check_eq("lit_rsp_result", rsp_result, x_res);
        check_eq("lit_rsp_zero", rsp_zero, x_zero);
        check_eq("lit_rsp_id", rsp_id, id[0]);
        check_eq("lit_rsp_err", rsp_err, x_err);
        step();
    endtask

    initial begin
        int guard;
        int unsigned cnt_before;
        rsp_ready = 1'b1;
        #2;
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_op_count", op_count, 16'd0);
        check_eq("rst_alu_a", alu_a, 32'd0);
        check_eq("rst_rsp_result", rsp_result, 32'd0);
        check_eq("rst_readies", {req0_ready, req1_ready}, 2'b00);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step();

        run_one(0, 3'b000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
        #1 check_eq("lit_op_count_1", op_count, 16'd1);
        run_one(1, 3'b100, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0);
        run_one(0, 3'b110, 32'd0, 32'h0000_1234, 32'h1234_0000, 1'b0, 1'b0);
`ifdef ALU_ARB_ILLEGAL_OP_EN
        run_one(1, 3'b111, 32'd3, 32'd4, 32'd0, 1'b1, 1'b1);
`else
        run_one(1, 3'b111, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0);
`endif

        // Tie arbitration straight out of reset
        rst_n = 1'b0; #1; rst_n = 1'b1; model_reset();
        @(negedge clk);
        acc_ids.delete();
        drive(0, 3'b000, 32'd100, 32'd1);
        drive(1, 3'b000, 32'd200, 32'd2);
        guard = 0;
        while (acc_ids.size() < 4 && guard < 30) begin
            step(); guard++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check_eq("tie_accepts", acc_ids.size(), 4);
        if (acc_ids.size() >= 4) begin
            check_eq("tie_order0", acc_ids[0], 0);
            check_eq("tie_order1", acc_ids[1], 1);
            check_eq("tie_order2", acc_ids[2], 0);
            check_eq("tie_order3", acc_ids[3], 1);
        end
        for (int i = 0; i < 3; i++) step();

        // Backpressure: response held, no new accept while stalled
        rsp_ready = 1'b0;
        drive(0, 3'b010, 32'hF0F0_0000, 32'h0F0F_0000);
        step();
        drive(1, 3'b001, 32'd3, 32'd1);
        step();
        cnt_before = m_cnt;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("stall_no_accept", m_pend, 1'b1);
        end
        rsp_ready = 1'b1;
        step();
        #1 check_eq("stall_count", op_count, 16'(cnt_before + 1));
        check_eq("stall_reaccept", req0_ready | req1_ready, 1'b1);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Reset while in EXEC
        drive(0, 3'b000, 32'd10, 32'd20);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("mid_rst_alu_a", alu_a, 32'd0);
        check_eq("mid_rst_alu_b", alu_b, 32'd0);
        check_eq("mid_rst_op_count", op_count, 16'd0);
        check_eq("mid_rst_rsp_result", rsp_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step();
        step();
        check_eq("post_rst_no_rsp", rsp_valid, 1'b0);
        run_one(0, 3'b000, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
        #1 check_eq("post_rst_count", op_count, 16'd1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_op = 3'($urandom_range(0, 7));
            req1_op = 3'($urandom_range(0, 7));
            req0_a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            req0_b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            req1_a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            req1_b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
